// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - size encodings, FSM states and byte-enable constants for mem_access_unit
package mau_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mau_state_e;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_B1   = 4'b0010;
   localparam logic [3:0] BE_B2   = 4'b0100;
   localparam logic [3:0] BE_B3   = 4'b1000;
   localparam logic [3:0] BE_LO   = 4'b0011;
   localparam logic [3:0] BE_HI   = 4'b1100;
   localparam logic [3:0] BE_ALL  = 4'b1111;

   // Half needs addr[0]=0, word (and the 11 encoding) needs addr[1:0]=0
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
      logic m;
      case (sz)
         SZ_BYTE: m = 1'b0;
         SZ_HALF: m = lo[0];
         default: m = (lo != 2'b00);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mau_if.sv
// rtl/mau_if.sv - req/ack data-memory bus between mem_access_unit and memory
interface mau_if;
   logic        memReq;
   logic        memWE;
   logic [31:0] memAddr;
   logic [31:0] memWData;
   logic [3:0]  memBE;
   logic        memAck;
   logic [31:0] memRData;

   modport master (
      output memReq, memWE, memAddr, memWData, memBE,
      input  memAck, memRData
   );

   modport slave (
      input  memReq, memWE, memAddr, memWData, memBE,
      output memAck, memRData
   );
endinterface

// File: rtl/mau_lane_align.sv
// rtl/mau_lane_align.sv - little-endian lane steering for stores and load extraction/extension
module mau_lane_align
   import mau_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  offset_i,
   input  logic        unsigned_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   output logic [31:0] load_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Write data is replicated so the selected lane always carries it; BE picks the lane
   always_comb begin
      wdata_o     = store_data_i;
      be_o        = BE_ALL;
      load_data_o = rdata_i;
      byte_sel    = rdata_i[7:0];
      half_sel    = rdata_i[15:0];
      case (size_i)
         SZ_BYTE: begin
            wdata_o = {4{store_data_i[7:0]}};
            case (offset_i)
               2'd0: begin be_o = BE_B0; byte_sel = rdata_i[7:0];   end
               2'd1: begin be_o = BE_B1; byte_sel = rdata_i[15:8];  end
               2'd2: begin be_o = BE_B2; byte_sel = rdata_i[23:16]; end
               default: begin be_o = BE_B3; byte_sel = rdata_i[31:24]; end
            endcase
            load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            wdata_o = {2{store_data_i[15:0]}};
            if (offset_i[1]) begin
               be_o     = BE_HI;
               half_sel = rdata_i[31:16];
            end else begin
               be_o     = BE_LO;
               half_sel = rdata_i[15:0];
            end
            load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         end
         default: begin
            wdata_o     = store_data_i;
            be_o        = BE_ALL;
            load_data_o = rdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequenced load/store port; optional MAU_MISALIGN_TRAP_EN adds misalign trap
module mem_access_unit
   import mau_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        mRD,
   input  logic        mWR,
   input  logic [1:0]  size,
   input  logic        unsignedLoad,
   input  logic [31:0] addr,
   input  logic [31:0] storeData,
   output logic        busy,
   output logic        done,
   output logic [31:0] DataOut,
   mau_if.master       bus
`ifdef MAU_MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   mau_state_e  state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic        uns_q, uns_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] dout_q, dout_d;
`ifdef MAU_MISALIGN_TRAP_EN
   logic        mis_q, mis_d;
`endif

   logic [1:0]  lane_size;
   logic [1:0]  lane_off;
   logic        lane_uns;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_be;
   logic [31:0] lane_load;

   // One aligner serves both directions: live inputs while accepting, latched ones during the access
   assign lane_size = (state_q == IDLE) ? size         : size_q;
   assign lane_off  = (state_q == IDLE) ? addr[1:0]    : off_q;
   assign lane_uns  = (state_q == IDLE) ? unsignedLoad : uns_q;

   mau_lane_align u_align (
      .size_i       (lane_size),
      .offset_i     (lane_off),
      .unsigned_i   (lane_uns),
      .store_data_i (storeData),
      .rdata_i      (bus.memRData),
      .wdata_o      (lane_wdata),
      .be_o         (lane_be),
      .load_data_o  (lane_load)
   );

   // Next state and next register values; everything holds unless a transition updates it
   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      off_d   = off_q;
      uns_d   = uns_q;
      req_d   = req_q;
      we_d    = we_q;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      dout_d  = dout_q;
`ifdef MAU_MISALIGN_TRAP_EN
      mis_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               if (mRD | mWR) begin
`ifdef MAU_MISALIGN_TRAP_EN
                  if (misaligned(size, addr[1:0])) begin
                     state_d = DONE;
                     mis_d   = 1'b1;
                  end else begin
`else
                  begin
`endif
                     state_d = ACCESS;
                     size_d  = size;
                     off_d   = addr[1:0];
                     uns_d   = unsignedLoad;
                     req_d   = 1'b1;
                     we_d    = mWR;
                     maddr_d = {addr[31:2], 2'b00};
                     wdata_d = lane_wdata;
                     be_d    = lane_be;
                  end
               end else begin
                  state_d = DONE;
               end
            end
         end
         ACCESS: begin
            if (bus.memAck) begin
               state_d = DONE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               if (!we_q) begin
                  dout_d = lane_load;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched access attributes, registered bus outputs and load result
   always_ff @(posedge CLK) begin
      if (RST) begin
         size_q  <= SZ_BYTE;
         off_q   <= 2'b00;
         uns_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         maddr_q <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= BE_NONE;
         dout_q  <= 32'h0;
      end else begin
         size_q  <= size_d;
         off_q   <= off_d;
         uns_q   <= uns_d;
         req_q   <= req_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         dout_q  <= dout_d;
      end
   end

`ifdef MAU_MISALIGN_TRAP_EN
   // Misalign flag lives for the single DONE cycle of a trapped access
   always_ff @(posedge CLK) begin
      if (RST) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end

   assign misalign = mis_q;
`endif

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign DataOut      = dout_q;
   assign bus.memReq   = req_q;
   assign bus.memWE    = we_q;
   assign bus.memAddr  = maddr_q;
   assign bus.memWData = wdata_q;
   assign bus.memBE    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with random traffic
module tb_mem_access_unit;

   typedef struct {
      logic [31:0] dout;
      int          lat;
      logic        mis;
      int          start_cyc;
   } done_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
   } bus_exp_t;

   typedef struct {
      int          wt;
      logic [31:0] rd;
   } resp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic        mRD;
   logic        mWR;
   logic [1:0]  size;
   logic        unsignedLoad;
   logic [31:0] addr;
   logic [31:0] storeData;
   wire         busy;
   wire         done;
   wire  [31:0] DataOut;
`ifdef MAU_MISALIGN_TRAP_EN
   wire         misalign;
`endif

   mau_if bus ();

   mem_access_unit dut (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start),
      .mRD          (mRD),
      .mWR          (mWR),
      .size         (size),
      .unsignedLoad (unsignedLoad),
      .addr         (addr),
      .storeData    (storeData),
      .busy         (busy),
      .done         (done),
      .DataOut      (DataOut),
      .bus          (bus)
`ifdef MAU_MISALIGN_TRAP_EN
      ,
      .misalign     (misalign)
`endif
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int          tests = 0;
   int          fails = 0;
   done_exp_t   done_q[$];
   bus_exp_t    bus_q[$];
   resp_t       resp_q[$];
   logic [31:0] model_dout = 32'h0;
   logic        manual = 1'b0;
   logic        noise  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory responder: random wait states, garbage read data while waiting, stray acks when idle
   initial begin
      int          wcnt;
      logic [31:0] rd;
      resp_t       r;
      wcnt = -1;
      rd   = 32'h0;
      bus.memAck   = 1'b0;
      bus.memRData = 32'h0;
      forever begin
         @(negedge CLK);
         if (!manual) begin
            if (bus.memReq === 1'b1) begin
               if (wcnt < 0) begin
                  if (resp_q.size() > 0) begin
                     r    = resp_q.pop_front();
                     wcnt = r.wt;
                     rd   = r.rd;
                  end else begin
                     wcnt = 0;
                     rd   = $urandom;
                  end
               end
               if (wcnt == 0) begin
                  bus.memAck   = 1'b1;
                  bus.memRData = rd;
                  wcnt         = -1;
               end else begin
                  bus.memAck   = 1'b0;
                  bus.memRData = $urandom;
                  wcnt--;
               end
            end else begin
               bus.memAck   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
               bus.memRData = $urandom;
            end
         end
      end
   end

   // Monitor: pops expected bus requests and completions as the DUT presents them
   initial begin
      done_exp_t de;
      bus_exp_t  be;
      bus_exp_t  snap;
      logic      prev_req;
      prev_req = 1'b0;
      snap     = '{32'h0, 32'h0, 4'h0, 1'b0};
      forever begin
         @(negedge CLK);
         if (RST === 1'b0) begin
            if (done === 1'b1) begin
               if (done_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
               end else begin
                  de = done_q.pop_front();
                  chk("DataOut", DataOut, de.dout);
                  chk("latency", 32'(cyc - de.start_cyc), 32'(de.lat));
`ifdef MAU_MISALIGN_TRAP_EN
                  chk("misalign", {31'h0, misalign}, {31'h0, de.mis});
`endif
               end
            end
            if (bus.memReq === 1'b1 && !prev_req) begin
               if (bus_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_req: got memReq=1 expected no request (cycle %0d)", cyc);
               end else begin
                  be = bus_q.pop_front();
                  chk("memAddr", bus.memAddr, be.addr);
                  chk("memBE", {28'h0, bus.memBE}, {28'h0, be.be});
                  chk("memWE", {31'h0, bus.memWE}, {31'h0, be.we});
                  if (be.we) chk("memWData", bus.memWData, be.wdata);
               end
               snap = '{bus.memAddr, bus.memWData, bus.memBE, bus.memWE};
            end else if (bus.memReq === 1'b1) begin
               chk("hold_memAddr", bus.memAddr, snap.addr);
               chk("hold_memBE", {28'h0, bus.memBE}, {28'h0, snap.be});
               chk("hold_memWData", bus.memWData, snap.wdata);
            end
         end
         prev_req = (bus.memReq === 1'b1);
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge CLK);
      while (busy !== 1'b0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 200) chk("idle_timeout", {31'h0, busy}, 32'h0);
   endtask

   task automatic scramble_inputs();
      mRD          = 1'($urandom);
      mWR          = 1'($urandom);
      size         = 2'($urandom);
      unsignedLoad = 1'($urandom);
      addr         = $urandom;
      storeData    = $urandom;
   endtask

   // Reference model: expected bus request, completion latency and load result from plain arithmetic
   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdv,
                        input int wt, input logic poke);
      int          nb;
      int          off;
      logic [31:0] mask;
      logic [31:0] v;
      logic        mis;
      done_exp_t   de;
      bus_exp_t    b;
      resp_t       r;
      wait_idle();
      nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      off = (nb == 4) ? 0 : (int'(a[1:0]) / nb) * nb;
      mis = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
      mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`endif
      de.start_cyc = cyc;
      de.mis       = 1'b0;
      if (!rd && !wr) begin
         de.lat = 1;
      end else if (mis) begin
         de.lat = 1;
         de.mis = 1'b1;
      end else begin
         b.addr  = a & 32'hFFFF_FFFC;
         b.be    = 4'(((1 << nb) - 1) << off);
         b.we    = wr;
         b.wdata = (nb == 1) ? {24'h0, sd[7:0]} * 32'h0101_0101 :
                   (nb == 2) ? {16'h0, sd[15:0]} * 32'h0001_0001 : sd;
         bus_q.push_back(b);
         r.wt = wt;
         r.rd = rdv;
         resp_q.push_back(r);
         de.lat = 2 + wt;
         if (!wr) begin
            v = rdv >> (8 * off);
            if (nb < 4) begin
               mask = (32'd1 << (8 * nb)) - 32'd1;
               v    = v & mask;
               if (!uns && v[8 * nb - 1]) v = v | ~mask;
            end
            model_dout = v;
         end
      end
      de.dout = model_dout;
      done_q.push_back(de);
      mRD          = rd;
      mWR          = wr;
      size         = sz;
      unsignedLoad = uns;
      addr         = a;
      storeData    = sd;
      start        = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      scramble_inputs();
      if (poke) begin
         start = 1'b1;
         mRD   = 1'b1;
         @(negedge CLK);
         start = 1'b0;
      end
   endtask

   task automatic reset_mid_access();
      bus_exp_t b;
      wait_idle();
      manual     = 1'b1;
      bus.memAck = 1'b0;
      b = '{32'h0000_0040, 32'h0, 4'hF, 1'b0};
      bus_q.push_back(b);
      mRD   = 1'b1;
      mWR   = 1'b0;
      size  = 2'b10;
      addr  = 32'h0000_0040;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      @(negedge CLK);
      RST          = 1'b1;
      bus.memAck   = 1'b1;
      bus.memRData = 32'hCAFE_F00D;
      @(negedge CLK);
      RST = 1'b0;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_memReq", {31'h0, bus.memReq}, 32'h0);
      chk("rst_memWE", {31'h0, bus.memWE}, 32'h0);
      chk("rst_memAddr", bus.memAddr, 32'h0);
      chk("rst_memWData", bus.memWData, 32'h0);
      chk("rst_memBE", {28'h0, bus.memBE}, 32'h0);
      chk("rst_DataOut", DataOut, 32'h0);
      @(negedge CLK);
      chk("late_ack_busy", {31'h0, busy}, 32'h0);
      chk("late_ack_done", {31'h0, done}, 32'h0);
      chk("late_ack_DataOut", DataOut, 32'h0);
      bus.memAck = 1'b0;
      manual     = 1'b0;
      model_dout = 32'h0;
   endtask

   initial begin
      RST   = 1'b1;
      start = 1'b0;
      scramble_inputs();
      repeat (3) @(negedge CLK);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_done", {31'h0, done}, 32'h0);
      chk("reset_memReq", {31'h0, bus.memReq}, 32'h0);
      chk("reset_memWE", {31'h0, bus.memWE}, 32'h0);
      chk("reset_memAddr", bus.memAddr, 32'h0);
      chk("reset_memWData", bus.memWData, 32'h0);
      chk("reset_memBE", {28'h0, bus.memBE}, 32'h0);
      chk("reset_DataOut", DataOut, 32'h0);
`ifdef MAU_MISALIGN_TRAP_EN
      chk("reset_misalign", {31'h0, misalign}, 32'h0);
`endif
      RST = 1'b0;

      issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 32'h80FF_FFFF, 3, 1'b0);
      issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 32'h80FF_FFFF, 3, 1'b0);
      issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 32'h8001_0000, 1, 1'b0);
      issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 32'h0, 2, 1'b1);
      reset_mid_access();
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0, 32'h1357_9BDF, 0, 1'b0);
      issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b1);
      issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_005A, 32'h0, 0, 1'b0);
      issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0030, 32'h0, 32'hA5A5_0F0F, 0, 1'b0);

      noise = 1'b1;
      for (int i = 0; i < 200; i++) begin
         logic rd_r;
         logic wr_r;
         rd_r = 1'($urandom);
         wr_r = 1'($urandom);
         if ($urandom_range(0, 9) != 0 && !rd_r && !wr_r) rd_r = 1'b1;
         issue(rd_r, wr_r, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
               $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
      end
      noise = 1'b0;

      wait_idle();
      repeat (4) @(negedge CLK);
      chk("done_queue_empty", 32'(done_q.size()), 32'h0);
      chk("bus_queue_empty", 32'(bus_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish within time limit");
      $fatal(1);
   end

endmodule
